// File: rtl/euler_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : euler_step_sequencer
// Purpose  : Runs semi-implicit Euler orbit steps on one shared FP unit,
//            issuing a fixed 15-op microprogram per step.
// Revision : 1.0  initial release
// ============================================================================
module euler_step_sequencer #(
    parameter logic [31:0] GM_DT   = 32'h3F800000,
    parameter logic [31:0] DT      = 32'h3F800000,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_valid,
    input  logic [31:0] init_x,
    input  logic [31:0] init_y,
    input  logic [31:0] init_vx,
    input  logic [31:0] init_vy,
    input  logic        start,
    input  logic [15:0] n_steps,
    output logic        fp_req_valid,
    input  logic        fp_req_ready,
    output logic [1:0]  fp_op,
    output logic [31:0] fp_a,
    output logic [31:0] fp_b,
    input  logic        fp_res_valid,
    input  logic [31:0] fp_res,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] vx,
    output logic [31:0] vy,
    output logic        busy,
    output logic        step_done,
    output logic        run_done,
    output logic [15:0] steps_left,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_STEP_END = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [1:0]  OP_MUL    = 2'd0;
    localparam logic [1:0]  OP_ADD    = 2'd1;
    localparam logic [1:0]  OP_SUB    = 2'd2;
    localparam logic [1:0]  OP_ISQ    = 2'd3;
    // Operand/destination codes: 0..3 state, 4..5 temps, 6..7 constant operands
    localparam logic [2:0]  R_X       = 3'd0;
    localparam logic [2:0]  R_Y       = 3'd1;
    localparam logic [2:0]  R_VX      = 3'd2;
    localparam logic [2:0]  R_VY      = 3'd3;
    localparam logic [2:0]  R_T0      = 3'd4;
    localparam logic [2:0]  R_T1      = 3'd5;
    localparam logic [2:0]  K_GM      = 3'd6;
    localparam logic [2:0]  K_DT      = 3'd7;
    localparam logic [3:0]  C_LAST_PC = 4'd14;
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] dst;
    } uop_t;

    function automatic uop_t ucode(input logic [3:0] pc);
        case (pc)
            4'd0:    return '{OP_MUL, R_X,  R_X,  R_T0};
            4'd1:    return '{OP_MUL, R_Y,  R_Y,  R_T1};
            4'd2:    return '{OP_ADD, R_T0, R_T1, R_T0};
            4'd3:    return '{OP_ISQ, R_T0, R_T0, R_T1};
            4'd4:    return '{OP_MUL, R_T1, R_T1, R_T0};
            4'd5:    return '{OP_MUL, R_T0, R_T1, R_T0};
            4'd6:    return '{OP_MUL, K_GM, R_T0, R_T0};
            4'd7:    return '{OP_MUL, R_X,  R_T0, R_T1};
            4'd8:    return '{OP_SUB, R_VX, R_T1, R_VX};
            4'd9:    return '{OP_MUL, R_Y,  R_T0, R_T1};
            4'd10:   return '{OP_SUB, R_VY, R_T1, R_VY};
            4'd11:   return '{OP_MUL, R_VX, K_DT, R_T1};
            4'd12:   return '{OP_ADD, R_X,  R_T1, R_X};
            4'd13:   return '{OP_MUL, R_VY, K_DT, R_T1};
            default: return '{OP_ADD, R_Y,  R_T1, R_Y};
        endcase
    endfunction

    function automatic logic [2:0] dst_of(input logic [3:0] pc);
        uop_t u;
        u = ucode(pc);
        return u.dst;
    endfunction

    function automatic logic [31:0] operand(input logic [2:0] sel, input logic [5:0][31:0] r);
        case (sel)
            K_GM:    return GM_DT;
            K_DT:    return DT;
            default: return r[sel];
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        pc_q, pc_d;
    // wrk holds the in-flight step; arch is what was committed at the last step end
    logic [5:0][31:0]  wrk_q, wrk_d;
    logic [3:0][31:0]  arch_q, arch_d;
    logic [15:0]       steps_q, steps_d;
    logic [15:0]       wait_q, wait_d;
    logic              error_q, error_d;
    logic              fp_req_valid_q, fp_req_valid_d;
    logic [1:0]        fp_op_q, fp_op_d;
    logic [31:0]       fp_a_q, fp_a_d;
    logic [31:0]       fp_b_q, fp_b_d;
    logic              busy_q, busy_d;
    logic              step_done_q, step_done_d;
    logic              run_done_q, run_done_d;
    uop_t              uop_nxt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrk_d   = wrk_q;
        arch_d  = arch_q;
        steps_d = steps_q;
        wait_d  = wait_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (init_valid) begin
                    arch_d     = {init_vy, init_vx, init_y, init_x};
                    wrk_d[3:0] = {init_vy, init_vx, init_y, init_x};
                end else if (start) begin
                    error_d = 1'b0;
                    if (n_steps == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        steps_d = n_steps;
                        pc_d    = 4'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fp_req_ready) begin
                    wait_d  = 16'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fp_res_valid) begin
                    wrk_d[dst_of(pc_q)] = fp_res;
                    if (pc_q == C_LAST_PC) begin
                        arch_d  = wrk_d[3:0];
                        steps_d = (steps_q != 16'd0) ? steps_q - 16'd1 : 16'd0;
                        state_d = S_STEP_END;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (wait_q == C_TIMEOUT) begin
                    // Abandon the partial step so outputs and working copy agree
                    wrk_d[3:0] = arch_q;
                    error_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_STEP_END: begin
                if (steps_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        fp_req_valid_d = (state_d == S_ISSUE);
        busy_d         = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_STEP_END);
        step_done_d    = (state_d == S_STEP_END);
        run_done_d     = (state_d == S_DONE);

        uop_nxt = ucode(pc_d);
        fp_op_d = 2'd0;
        fp_a_d  = 32'd0;
        fp_b_d  = 32'd0;
        if (fp_req_valid_d) begin
            fp_op_d = uop_nxt.op;
            fp_a_d  = operand(uop_nxt.a, wrk_d);
            fp_b_d  = (uop_nxt.op == OP_ISQ) ? 32'd0 : operand(uop_nxt.b, wrk_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= 4'd0;
            wrk_q          <= '0;
            arch_q         <= '0;
            steps_q        <= 16'd0;
            wait_q         <= 16'd0;
            error_q        <= 1'b0;
            fp_req_valid_q <= 1'b0;
            fp_op_q        <= 2'd0;
            fp_a_q         <= 32'd0;
            fp_b_q         <= 32'd0;
            busy_q         <= 1'b0;
            step_done_q    <= 1'b0;
            run_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            wrk_q          <= wrk_d;
            arch_q         <= arch_d;
            steps_q        <= steps_d;
            wait_q         <= wait_d;
            error_q        <= error_d;
            fp_req_valid_q <= fp_req_valid_d;
            fp_op_q        <= fp_op_d;
            fp_a_q         <= fp_a_d;
            fp_b_q         <= fp_b_d;
            busy_q         <= busy_d;
            step_done_q    <= step_done_d;
            run_done_q     <= run_done_d;
        end
    end

    assign fp_req_valid = fp_req_valid_q;
    assign fp_op        = fp_op_q;
    assign fp_a         = fp_a_q;
    assign fp_b         = fp_b_q;
    assign x            = arch_q[0];
    assign y            = arch_q[1];
    assign vx           = arch_q[2];
    assign vy           = arch_q[3];
    assign busy         = busy_q;
    assign step_done    = step_done_q;
    assign run_done     = run_done_q;
    assign steps_left   = steps_q;
    assign error        = error_q;

endmodule
`default_nettype wire
